// File: rtl/inst_fifo.sv
// Dual-lane instruction FIFO between fetch and decode: two pushes and two pops
// per cycle, whole-buffer flush on redirect, and a registered full flag for fetch throttling.
module inst_fifo #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid1,
  input  logic              push_valid2,
  input  logic [DATA_W-1:0] inst_in1,
  input  logic [DATA_W-1:0] inst_in2,
  input  logic [PC_W-1:0]   pc_in1,
  input  logic [PC_W-1:0]   pc_in2,
  input  logic              pop1,
  input  logic              pop2,
  input  logic              flush,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic [DATA_W-1:0] inst_out1,
  output logic [DATA_W-1:0] inst_out2,
  output logic [PC_W-1:0]   pc_out1,
  output logic [PC_W-1:0]   pc_out2,
  output logic [CNT_W-1:0]  count,
  output logic              instbuf_full
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             wr1, wr2, rd1, rd2;

  // Pointer arithmetic wraps for free since DEPTH is a power of two.
  assign head_p1 = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
  assign tail_p1 = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};

  assign out_valid1 = (count_q != '0);
  assign out_valid2 = (count_q > {{(CNT_W-1){1'b0}}, 1'b1});
  assign inst_out1  = mem_q[head_q].inst;
  assign pc_out1    = mem_q[head_q].pc;
  assign inst_out2  = mem_q[head_p1].inst;
  assign pc_out2    = mem_q[head_p1].pc;
  assign count        = count_q;
  assign instbuf_full = full_q;

  // Full is the registered value, so space freed by this cycle's pop is not reusable yet.
  assign wr1 = push_valid1 & ~full_q & ~flush;
  assign wr2 = wr1 & push_valid2;
  assign rd1 = pop1 & out_valid1;
  assign rd2 = rd1 & pop2 & out_valid2;

  always_comb begin
    head_d  = head_q + {{(PTR_W-1){1'b0}}, rd1} + {{(PTR_W-1){1'b0}}, rd2};
    tail_d  = tail_q + {{(PTR_W-1){1'b0}}, wr1} + {{(PTR_W-1){1'b0}}, wr2};
    count_d = count_q + {{(CNT_W-1){1'b0}}, wr1} + {{(CNT_W-1){1'b0}}, wr2}
                      - {{(CNT_W-1){1'b0}}, rd1} - {{(CNT_W-1){1'b0}}, rd2};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    full_d = (count_d > CNT_W'(DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Entry storage carries no reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr1) mem_q[tail_q]  <= '{inst: inst_in1, pc: pc_in1};
      if (wr2) mem_q[tail_p1] <= '{inst: inst_in2, pc: pc_in2};
    end
  end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Parametrised dual-lane instruction FIFO between IF and ID; replaces the IF/ID pipeline register.
- Accepts up to two fetched instructions per cycle, each with its PC, and presents up to two oldest entries per cycle to the decoder.
- Supports whole-buffer flush on branch redirect and a registered occupancy/full indication that IF uses to throttle fetch.

Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, PC width
- DEPTH, 8, number of entries; power of two, minimum 4
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_valid1  in  1  lane-1 write request (older instruction)
- push_valid2  in  1  lane-2 write request; legal only with push_valid1=1
- inst_in1  in  DATA_W  lane-1 instruction
- inst_in2  in  DATA_W  lane-2 instruction
- pc_in1  in  PC_W  lane-1 PC
- pc_in2  in  PC_W  lane-2 PC
- pop1  in  1  ID consumes out slot 1
- pop2  in  1  ID consumes out slot 2; legal only with pop1=1
- flush  in  1  branch redirect; discard all entries
- out_valid1  out  1  slot 1 holds a valid entry
- out_valid2  out  1  slot 2 holds a valid entry
- inst_out1  out  DATA_W  oldest instruction
- inst_out2  out  DATA_W  second-oldest instruction
- pc_out1  out  PC_W  PC of inst_out1
- pc_out2  out  PC_W  PC of inst_out2
- count  out  CNT_W  current occupancy, 0..DEPTH
- instbuf_full  out  1  registered; 1 when free slots < 2

Behaviour:
- Storage: circular array of DEPTH {inst,pc} entries; head (read) and tail (write) pointers of log2(DEPTH) bits wrap modulo DEPTH; count tracks occupancy.
- Reset (rst=1 at posedge): head=0, tail=0, count=0, instbuf_full=0. Resulting outputs: out_valid1=0, out_valid2=0. Entry contents are not reset; inst_out/pc_out are don't-care while the matching valid is 0.
- Read side is combinational from the registered state:
  - out_valid1 = (count>=1); out_valid2 = (count>=2)
  - slot 1 = entry[head]; slot 2 = entry[head+1 mod DEPTH]
- Pop:
  - Effective pop number npop = (pop1 & out_valid1) + (pop2 & pop1 & out_valid2).
  - pop2 without pop1 is ignored; pops of invalid slots are ignored.
  - head += npop at posedge.
- Push:
  - Accepted only when instbuf_full=0 (registered value from the previous edge); when full, both lanes are dropped, with no partial push.
  - npush = push_valid1 + (push_valid1 & push_valid2); push_valid2 alone is ignored.
  - Lane 1 is written to entry[tail], lane 2 to entry[tail+1]; tail += npush.
- Simultaneous push and pop in a cycle: both take effect; count_next = count + npush - npop. Space freed by a same-cycle pop is not usable by that cycle's push, since full is based on registered count.
- Latency: a pushed entry appears on the out ports the cycle after the push edge. Empty-to-pop bypass is not supported.
- instbuf_full_next = (DEPTH - count_next) < 2. This guarantees a 2-wide push never overflows.
- Flush has the highest priority after rst:
  - At posedge, head=tail=0, count=0, instbuf_full=0.
  - Any push or pop in the same cycle is discarded.
  - The cycle after flush, out_valid1/2=0 and IF may push the redirect-target instructions.
- Reset mid-operation overrides flush, push and pop; state returns to the reset values.
- Ordering: the output order strictly equals the push order (lane 1 before lane 2 within a cycle).
- Illegal inputs (push_valid2 without push_valid1, pop2 without pop1) have no effect. The bench treats them as assertions.

Test Plan:
- Reset then idle -> count=0, out_valid1=0, out_valid2=0, instbuf_full=0.
- Single pushes, DEPTH=8:
  - Stimulus: push one entry per cycle, inst=0x100+i, pc=0x1000+4i, for i=0..6, no pops.
  - Required: count=7 and instbuf_full=1 after the 7th push. A further 1-wide push is dropped and count stays 7.
  - Then pop1 once -> slot 1 shows 0x101/0x1004.
- Dual push/dual pop wrap: 20 cycles of 2-wide pushes (when not full) and 2-wide pops (when out_valid2) -> pointers wrap past 7; pop sequence is 0..39 with no loss or duplication; count never exceeds 8.
- Simultaneous 2-push and 1-pop at count=4 -> count=5 next cycle; slot 1 = former slot 2.
- Flush with count=5 while pushing 2 and popping 2 -> next cycle count=0, out_valid1=0, instbuf_full=0. A following push of 0xAA/0xBB appears in slots 1 and 2 one cycle later.
- Illegal and edge inputs:
  - pop1 while empty -> no change.
  - push_valid2 alone -> no change.
  - rst asserted at count=6 together with a push -> count=0 next cycle.
